// File: rtl/multiply_pipelined_pkg.sv
// Shared execute-stage types for the pipelined multiplier.
package multiply_pipelined_pkg;

  typedef logic [6:0] Tag;
  typedef logic [4:0] RegNm;
  typedef logic [6:0] SqN;

  typedef enum logic [3:0] {
    FLAGS_NONE   = 4'd0,
    FLAGS_BRK    = 4'd1,
    FLAGS_TRAP   = 4'd2,
    FLAGS_EXCEPT = 4'd3
  } Flags;

  typedef enum logic [2:0] {
    MUL_MUL   = 3'd0,
    MUL_MULH  = 3'd1,
    MUL_MULSU = 3'd2,
    MUL_MULU  = 3'd3,
    MUL_MULW  = 3'd4
  } MulOp;

  // Operand/result fields are sized for the widest core; narrower
  // instances use the low XLEN bits and return zero in the upper bits.
  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic [MAX_XLEN-1:0] srcA;
    logic [MAX_XLEN-1:0] srcB;
    MulOp                opcode;
    Tag                  tagDst;
    RegNm                nmDst;
    SqN                  sqN;
    logic                valid;
  } EX_UOp;

  typedef struct packed {
    logic [MAX_XLEN-1:0] result;
    Tag                  tagDst;
    RegNm                nmDst;
    SqN                  sqN;
    Flags                flags;
    logic                doNotCommit;
    logic                valid;
  } RES_UOp;

  // Bookkeeping carried unchanged down the pipe.
  typedef struct packed {
    Tag   tagDst;
    RegNm nmDst;
    SqN   sqN;
  } mul_meta_t;

  // Result-formatting controls decided at operand prep.
  typedef struct packed {
    logic invert;
    logic high;
    logic word;
  } mul_ctrl_t;

  // Younger than the mispredicted branch: wrapped sequence distance > 0.
  function automatic logic is_younger(SqN s, BranchProv br);
    SqN d;
    d = s - br.sqN;
    return br.taken && ($signed(d) > 0);
  endfunction

endpackage

// File: rtl/mul_accum_stage.sv
// One partial-product stage: adds srcA * srcB[slice IDX] into the running sum.
module mul_accum_stage
  import multiply_pipelined_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BITS = 8,
  parameter int IDX  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  BranchProv         branch,
  input  logic              in_valid,
  input  mul_meta_t         in_meta,
  input  mul_ctrl_t         in_ctrl,
  input  logic [XLEN-1:0]   in_src_a,
  input  logic [XLEN-1:0]   in_src_b,
  input  logic [2*XLEN-1:0] in_res,
  output logic              out_valid,
  output mul_meta_t         out_meta,
  output mul_ctrl_t         out_ctrl,
  output logic [XLEN-1:0]   out_src_a,
  output logic [XLEN-1:0]   out_src_b,
  output logic [2*XLEN-1:0] out_res
);

  typedef struct packed {
    logic [XLEN-1:0]   srcA;
    logic [XLEN-1:0]   srcB;
    logic [2*XLEN-1:0] res;
    mul_ctrl_t         ctrl;
    mul_meta_t         meta;
    logic              valid;
  } stage_t;

  stage_t            stg_q, stg_d;
  logic [2*XLEN-1:0] pp;

  // Next stage contents: hold while stalled, otherwise accumulate; flush either way.
  always_comb begin
    pp = ({{XLEN{1'b0}}, in_src_a} *
          {{(2*XLEN-BITS){1'b0}}, in_src_b[BITS*IDX +: BITS]}) << (BITS*IDX);
    stg_d = stg_q;
    if (!hold) begin
      stg_d.srcA  = in_src_a;
      stg_d.srcB  = in_src_b;
      stg_d.res   = in_res + pp;
      stg_d.ctrl  = in_ctrl;
      stg_d.meta  = in_meta;
      stg_d.valid = in_valid;
    end
    if (is_younger(stg_d.meta.sqN, branch)) stg_d.valid = 1'b0;
  end

  // Stage register; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    stg_q <= stg_d;
    if (!rst) stg_q.valid <= 1'b0;
  end

  assign out_valid = stg_q.valid;
  assign out_meta  = stg_q.meta;
  assign out_ctrl  = stg_q.ctrl;
  assign out_src_a = stg_q.srcA;
  assign out_src_b = stg_q.srcB;
  assign out_res   = stg_q.res;

endmodule

// File: rtl/multiply_pipelined.sv
// Pipelined integer multiplier: input register, NUM_STAGES accumulate stages,
// output register, with result backpressure and branch flush.
module multiply_pipelined
  import multiply_pipelined_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NUM_STAGES = 4,
  localparam int BITS       = XLEN / NUM_STAGES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  output logic      OUT_busy,
  input  BranchProv IN_branch,
  input  EX_UOp     IN_uop,
  input  logic      IN_resultReady,
  output RES_UOp    OUT_uop
);

  typedef struct packed {
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    mul_ctrl_t       ctrl;
    mul_meta_t       meta;
    logic            valid;
  } pl0_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    mul_meta_t       meta;
    logic            valid;
  } out_t;

  pl0_t            pl0_q, pl0_d;
  out_t            out_q, out_d;
  logic            stall;
  logic [XLEN-1:0] op_a, op_b;
  mul_ctrl_t       ctrl;
  logic [XLEN-1:0] res_hi, res_lo, fin;

  logic      [NUM_STAGES:0]             pl_valid;
  mul_meta_t [NUM_STAGES:0]             pl_meta;
  mul_ctrl_t [NUM_STAGES:0]             pl_ctrl;
  logic      [NUM_STAGES:0][XLEN-1:0]   pl_src_a;
  logic      [NUM_STAGES:0][XLEN-1:0]   pl_src_b;
  logic      [NUM_STAGES:0][2*XLEN-1:0] pl_res;

  // The whole pipe freezes when the result bus refuses a valid output.
  assign stall    = out_q.valid && !IN_resultReady;
  assign OUT_busy = stall;

  // Operand prep: signed forms become unsigned magnitudes plus a negate flag.
  always_comb begin
    op_a      = IN_uop.srcA[XLEN-1:0];
    op_b      = IN_uop.srcB[XLEN-1:0];
    ctrl      = '0;
    ctrl.word = (XLEN == 64) && (IN_uop.opcode == MUL_MULW);
    ctrl.high = !(IN_uop.opcode inside {MUL_MUL, MUL_MULW});
    case (IN_uop.opcode)
      MUL_MULH: begin
        ctrl.invert = op_a[XLEN-1] ^ op_b[XLEN-1];
        if (op_a[XLEN-1]) op_a = -op_a;
        if (op_b[XLEN-1]) op_b = -op_b;
      end
      MUL_MULSU: begin
        ctrl.invert = op_a[XLEN-1];
        if (op_a[XLEN-1]) op_a = -op_a;
      end
      default: ;
    endcase
    if (ctrl.word) begin
      op_a = XLEN'(signed'(op_a[31:0]));
      op_b = XLEN'(signed'(op_b[31:0]));
    end
  end

  // Input register: capture an issued uop unless stalled; flush applies to both.
  always_comb begin
    pl0_d = pl0_q;
    if (!stall) begin
      pl0_d.srcA        = op_a;
      pl0_d.srcB        = op_b;
      pl0_d.ctrl        = ctrl;
      pl0_d.meta.tagDst = IN_uop.tagDst;
      pl0_d.meta.nmDst  = IN_uop.nmDst;
      pl0_d.meta.sqN    = IN_uop.sqN;
      pl0_d.valid       = en && IN_uop.valid;
    end
    if (is_younger(pl0_d.meta.sqN, IN_branch)) pl0_d.valid = 1'b0;
  end

  // Input register state.
  always_ff @(posedge clk) begin
    pl0_q <= pl0_d;
    if (!rst) pl0_q.valid <= 1'b0;
  end

  assign pl_valid[0] = pl0_q.valid;
  assign pl_meta[0]  = pl0_q.meta;
  assign pl_ctrl[0]  = pl0_q.ctrl;
  assign pl_src_a[0] = pl0_q.srcA;
  assign pl_src_b[0] = pl0_q.srcB;
  assign pl_res[0]   = '0;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    mul_accum_stage #(
      .XLEN(XLEN),
      .BITS(BITS),
      .IDX (i)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall),
      .branch   (IN_branch),
      .in_valid (pl_valid[i]),
      .in_meta  (pl_meta[i]),
      .in_ctrl  (pl_ctrl[i]),
      .in_src_a (pl_src_a[i]),
      .in_src_b (pl_src_b[i]),
      .in_res   (pl_res[i]),
      .out_valid(pl_valid[i+1]),
      .out_meta (pl_meta[i+1]),
      .out_ctrl (pl_ctrl[i+1]),
      .out_src_a(pl_src_a[i+1]),
      .out_src_b(pl_src_b[i+1]),
      .out_res  (pl_res[i+1])
    );
  end

  // Result select and output register; a dropped output is replaced the same edge.
  always_comb begin
    res_hi = pl_res[NUM_STAGES][2*XLEN-1:XLEN];
    res_lo = pl_res[NUM_STAGES][XLEN-1:0];
    fin    = res_lo;
    if (pl_ctrl[NUM_STAGES].high)
      fin = pl_ctrl[NUM_STAGES].invert ? (~res_hi + XLEN'(res_lo == '0)) : res_hi;
    else if (pl_ctrl[NUM_STAGES].word)
      fin = XLEN'(signed'(res_lo[31:0]));
    out_d = out_q;
    if (!stall) begin
      out_d.result = fin;
      out_d.meta   = pl_meta[NUM_STAGES];
      out_d.valid  = pl_valid[NUM_STAGES];
    end
    if (is_younger(out_d.meta.sqN, IN_branch)) out_d.valid = 1'b0;
  end

  // Output register state.
  always_ff @(posedge clk) begin
    out_q <= out_d;
    if (!rst) out_q.valid <= 1'b0;
  end

  // Drive the result bus; narrow instances zero the upper result bits.
  always_comb begin
    OUT_uop             = '0;
    OUT_uop.result      = MAX_XLEN'(out_q.result);
    OUT_uop.tagDst      = out_q.meta.tagDst;
    OUT_uop.nmDst       = out_q.meta.nmDst;
    OUT_uop.sqN         = out_q.meta.sqN;
    OUT_uop.flags       = FLAGS_NONE;
    OUT_uop.doNotCommit = 1'b0;
    OUT_uop.valid       = out_q.valid;
  end

  // Operand bits above XLEN and the last stage's operand copies are not needed.
  logic unused_bits;
  assign unused_bits = ^{IN_uop.srcA, IN_uop.srcB,
                         pl_src_a[NUM_STAGES], pl_src_b[NUM_STAGES]};

endmodule
